// File: rtl/usb_tx_hash_feeder.sv
// Feeds a 256-bit hash to the USB TX top level as PID word + 16 words on read_enable rising edges.
// Optional watchdog abort: define FEED_TIMEOUT_EN.
module usb_tx_hash_feeder #(
   parameter int unsigned NUM_WORDS      = 16,
   parameter logic [15:0] PID_WORD       = 16'h80D2,
   parameter int unsigned START_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [NUM_WORDS*16-1:0] hash_in,
   input  logic                    read_enable,
   input  logic                    tx_error,
   input  logic                    eop_in,
   output logic                    transmit_start,
   output logic [15:0]             tx_data,
   output logic                    busy,
   output logic                    done,
   output logic                    feed_error
);
   localparam int unsigned HW = NUM_WORDS * 16;
   localparam int unsigned IW = $clog2(NUM_WORDS);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned SW = $clog2(START_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_EOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [HW-1:0]   hash_q, hash_d;
   logic [15:0]     tx_data_q, tx_data_d;
   logic [SW-1:0]   sc_q, sc_d;
   logic            ts_q, ts_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            pend_q, pend_d;
   logic            re_q, eop_q;
   logic            re_rise_c, abort_c, timeout_c;
   logic [IW-1:0]   widx_c;
   logic [15:0]     word_c;

   assign re_rise_c = read_enable & ~re_q;
   // Word 0 is the most significant 16 bits of the hash.
   assign widx_c    = IW'(NUM_WORDS - 1) - cnt_q[IW-1:0];
   assign word_c    = hash_q[{widx_c, 4'b0000} +: 16];
   assign abort_c   = (state_q != IDLE) && (tx_error || timeout_c);

`ifdef FEED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] wd_q, wd_d;

   assign timeout_c = (state_q != IDLE) && (wd_q == TW'(TIMEOUT_CYCLES - 1));

   // Watchdog restarts on any state change or TX word request.
   always_comb begin
      wd_d = '0;
      if ((state_d == state_q) && !re_rise_c && (state_q != IDLE)) wd_d = wd_q + TW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`else
   assign timeout_c = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hash_d    = hash_q;
      tx_data_d = tx_data_q;
      sc_d      = sc_q;
      ts_d      = ts_q;
      pend_d    = pend_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               hash_d    = hash_in;
               tx_data_d = PID_WORD;
               ts_d      = 1'b1;
               sc_d      = '0;
               cnt_d     = '0;
               pend_d    = 1'b0;
               state_d   = START;
            end
         end
         START: begin
            if (re_rise_c) pend_d = 1'b1;
            if (sc_q == SW'(START_CYCLES - 1)) begin
               ts_d    = 1'b0;
               pend_d  = 1'b0;
               state_d = STREAM;
               cnt_d   = '0;
               // An early request is served as the first word on STREAM entry.
               if (pend_q || re_rise_c) begin
                  tx_data_d = word_c;
                  cnt_d     = CW'(1);
               end
            end else begin
               sc_d = sc_q + SW'(1);
            end
         end
         STREAM: begin
            if (re_rise_c) begin
               tx_data_d = word_c;
               if (cnt_q == CW'(NUM_WORDS - 1)) begin
                  cnt_d   = CW'(NUM_WORDS);
                  state_d = WAIT_EOP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WAIT_EOP: begin
            if (eop_q && !eop_in) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort_c) begin
         state_d   = IDLE;
         ts_d      = 1'b0;
         cnt_d     = '0;
         pend_d    = 1'b0;
         tx_data_d = tx_data_q;
         done_d    = 1'b0;
         ferr_d    = 1'b1;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hash_q    <= '0;
         tx_data_q <= 16'h0000;
         sc_q      <= '0;
         ts_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         pend_q    <= 1'b0;
         re_q      <= 1'b0;
         eop_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hash_q    <= hash_d;
         tx_data_q <= tx_data_d;
         sc_q      <= sc_d;
         ts_q      <= ts_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         pend_q    <= pend_d;
         re_q      <= read_enable;
         eop_q     <= eop_in;
      end
   end

   assign transmit_start = ts_q;
   assign tx_data        = tx_data_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign feed_error     = ferr_q;
endmodule

// File: doc/usb_tx_hash_feeder.md
Name: usb_tx_hash_feeder

Overview:
- Producer-side companion to the USB TX top level. Supplies the 16-bit words that the transmitter pulls with read_enable.
- Accepts one 256-bit hash per load pulse. Raises transmit_start with the data-packet PID word, then serves the hash MSB-first as 16 words, one per read_enable rising edge.
- Waits for end-of-packet on the line before reporting done. Sits between the miner result logic and USB_tx_top_level.

Parameters:
- NUM_WORDS, 16, words per hash; the hash register width is NUM_WORDS*16.
- PID_WORD, 16'h80D2, word presented with transmit_start (SYNC/PID for a DATA packet).
- START_CYCLES, 2, clock cycles transmit_start is held high.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only when FEED_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle request to send hash_in; sampled only in IDLE.
- hash_in  in  NUM_WORDS*16  hash to send; captured on an accepted load.
- read_enable  in  1  TX word request; the rising edge is what counts.
- tx_error  in  1  TX error indication.
- eop_in  in  1  high while the line is SE0 (!d_plus_out && !d_minus_out).
- transmit_start  out  1  start request to TX.
- tx_data  out  16  word presented to TX.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a packet completes.
- feed_error  out  1  one-cycle pulse when a packet aborts.

Behaviour:
- Reset (async, rst=1): state IDLE; transmit_start=0, tx_data=16'h0000, busy=0, done=0, feed_error=0; word counter=0; hash register=0; read_enable edge-detect register=0.
- Edge detect: re_rise = read_enable & ~re_q, where re_q is read_enable registered. A read_enable held high for multiple cycles counts exactly once.
- IDLE:
  - load=1: capture hash_in, tx_data<=PID_WORD, transmit_start<=1, go START. Outputs change on the cycle after load.
  - load=0: hold.
- START:
  - Hold transmit_start=1 for START_CYCLES cycles, then drive it 0 and go STREAM with counter=0.
  - A re_rise during START is treated as the first STREAM request.
- STREAM:
  - On each re_rise: tx_data <= hash word[counter], where word 0 = hash[NUM_WORDS*16-1 -: 16]. Increment the counter.
  - Latency is 1 cycle from the re_rise sample to the new tx_data.
  - After word NUM_WORDS-1 is driven, go WAIT_EOP.
  - Between edges, tx_data holds its value.
- WAIT_EOP:
  - tx_data holds the last word; further re_rise edges are ignored.
  - On the falling edge of eop_in (registered eop_in=1, eop_in now 0): done=1 for one cycle, go IDLE.
- Abort: tx_error=1 in any non-IDLE state → next cycle: IDLE, transmit_start=0, feed_error=1 for one cycle, counter=0; tx_data keeps its last value.
- Simultaneous tx_error and re_rise: the abort wins and no word is advanced.
- Load while busy: ignored, with no side effects; the hash register is unchanged.
- Counter is 5 bits for the default and sized with $clog2(NUM_WORDS)+1 in general. It never wraps, because it saturates at NUM_WORDS when the state moves to WAIT_EOP.
- done and feed_error are never asserted in the same cycle.

Optional Feature:
- Macro: FEED_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every state entry and on every re_rise, and increments in START, STREAM and WAIT_EOP.
  - Reaching TIMEOUT_CYCLES aborts exactly as tx_error does (feed_error pulse, back to IDLE).
- Undefined: no watchdog logic; the block waits indefinitely in STREAM/WAIT_EOP.

Test Plan:
- Reset with rst=1 mid-STREAM (after word 5) → all outputs 0 and IDLE in the same cycle (async); after release, a new load of 256'h...F090 starts with tx_data=16'h80D2.
- load with hash 256'h00000000000080b66c911bd5ba14a74260057311eaeb1982802f7010f1a9f090; transmit_start high for 2 cycles; 16 read_enable pulses → tx_data sequence 0000,0000,0000,80b6,6c91,1bd5,ba14,a742,6005,7311,eaeb,1982,802f,7010,f1a9,f090; eop_in 1→0 → done pulse, busy=0.
- read_enable held high for 3 cycles per request → exactly one word advance per request; 17th pulse in WAIT_EOP leaves tx_data=f090.
- tx_error=1 after word 7 (same cycle as a read_enable edge) → feed_error pulse, no advance past 60057311's predecessor word a742, IDLE next cycle; next load restarts at word 0.
- Back-to-back: second load asserted during STREAM is ignored; a load one cycle after done → new packet begins, PID_WORD reappears.
- With FEED_TIMEOUT_EN and TIMEOUT_CYCLES=64: load, then no read_enable → feed_error at cycle 64 after STREAM entry; without the macro, busy stays 1 for 1000 cycles.
